seven_segment_scanner: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode seven-segment bank. It replaces per-digit combinational decoding with a single registered segment bus and a rotating digit enable.
- Adds the following over the single-digit decoder:
  - hex glyphs
  - leading-zero suppression
  - per-digit blanking and decimal points
  - anti-ghosting dead time
  - tear-free frame-synchronous value update
- Sits between the datapath (counters, results) and the board display pins.

---
 rtl/seven_segment_scanner.sv | 179 +++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver: registered segment bus, rotating
// digit enable, dead time between slots and frame-synchronous display updates.
module seven_segment_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 500,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    hex_mode,
   input  logic                    lz_en,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int VAL_W = 4 * NUM_DIGITS;

   // Internal logic works in active-low terms; these masks flip polarity at the pins.
   localparam logic [6:0]            SEG_INV = (ACTIVE_LOW != 0) ? '0 : '1;
   localparam logic                  DP_INV  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic [NUM_DIGITS-1:0] AN_INV  = (ACTIVE_LOW != 0) ? '0 : '1;

   localparam logic [6:0] GLYPH_OFF  = 7'b1111111;
   localparam logic [6:0] GLYPH_DASH = 7'b0111111;

   logic [CNT_W-1:0]      r_slot_cnt;
   logic [IDX_W-1:0]      r_digit_idx;
   logic [VAL_W-1:0]      r_pend_val;
   logic [NUM_DIGITS-1:0] r_pend_dp;
   logic                  r_pend_flag;
   logic [VAL_W-1:0]      r_act_val;
   logic [NUM_DIGITS-1:0] r_act_dp;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [NUM_DIGITS-1:0] r_an;
   logic                  r_frame_done;

   logic                  w_slot_end;
   logic                  w_frame_end;
   logic                  w_dead;
   logic [NUM_DIGITS-1:0] w_suppress;
   logic [3:0]            w_nibble;
   logic                  w_dp_req;
   logic                  w_blank;
   logic [NUM_DIGITS-1:0] w_onehot;
   logic [6:0]            w_seg_n;
   logic                  w_dp_n;
   logic [NUM_DIGITS-1:0] w_an_n;

   function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
      logic [6:0] g;
      g = GLYPH_OFF;
      case (nib)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         4'hF: g = 7'b0001110;
         default: g = GLYPH_OFF;
      endcase
      if (!hex && nib >= 4'hA) g = GLYPH_DASH;
      return g;
   endfunction

   assign w_slot_end  = (r_slot_cnt == CNT_W'(REFRESH_DIV - 1));
   assign w_frame_end = w_slot_end && (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= '0;
      end else if (w_slot_end) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= w_frame_end ? '0 : r_digit_idx + 1'b1;
      end else begin
         r_slot_cnt  <= r_slot_cnt + 1'b1;
      end
   end

   // A load coinciding with the boundary stays pending; the previous pending value goes live.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_val  <= '0;
         r_pend_dp   <= '0;
         r_pend_flag <= 1'b0;
         r_act_val   <= '0;
         r_act_dp    <= '0;
      end else begin
         if (w_frame_end && r_pend_flag) begin
            r_act_val <= r_pend_val;
            r_act_dp  <= r_pend_dp;
         end
         if (load) begin
            r_pend_val  <= value;
            r_pend_dp   <= dp_in;
            r_pend_flag <= 1'b1;
         end else if (w_frame_end) begin
            r_pend_flag <= 1'b0;
         end
      end
   end

   generate
      if (DEAD_CYCLES > 0) begin : g_dead
         assign w_dead = (int'(r_slot_cnt) < DEAD_CYCLES);
      end else begin : g_no_dead
         assign w_dead = 1'b0;
      end
   endgenerate

   // Zero run scanned from the most significant digit; digit 0 always displays.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      logic v_run;
      w_suppress = '0;
      v_run      = lz_en;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         v_run         = v_run && (r_act_val[4*i +: 4] == 4'h0);
         w_suppress[i] = v_run;
      end
   end

   assign w_nibble = r_act_val[4*int'(r_digit_idx) +: 4];
   assign w_dp_req = r_act_dp[r_digit_idx];
   assign w_blank  = blank_mask[r_digit_idx] | w_suppress[r_digit_idx];
   assign w_onehot = NUM_DIGITS'(1) << r_digit_idx;

   always_comb begin
      w_seg_n = GLYPH_OFF;
      w_dp_n  = 1'b1;
      w_an_n  = '1;
      if (!w_blank) begin
         w_seg_n = glyph(w_nibble, hex_mode);
         w_dp_n  = ~w_dp_req;
         if (!w_dead) w_an_n = ~w_onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg        <= GLYPH_OFF ^ SEG_INV;
         r_dp         <= 1'b1 ^ DP_INV;
         r_an         <= '1 ^ AN_INV;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_n ^ SEG_INV;
         r_dp         <= w_dp_n ^ DP_INV;
         r_an         <= w_an_n ^ AN_INV;
         r_frame_done <= w_frame_end;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (4 digits, 8-cycle slots, 2 dead cycles, active-low):
// table-driven display vectors checked through a per-digit scoreboard, plus timing sequences.
module tb_seven_segment_scanner;

   localparam int N = 4;
   localparam int R = 8;
   localparam int D = 2;
   localparam int FRAME = N * R;

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
   localparam logic [6:0] DASH = 7'b0111111, OFF = 7'b1111111;

   logic          clk = 1'b0;
   logic          rst;
   logic [4*N-1:0] value;
   logic [N-1:0]  dp_in;
   logic          load;
   logic          hex_mode;
   logic          lz_en;
   logic [N-1:0]  blank_mask;
   logic [6:0]    seg;
   logic          dp;
   logic [N-1:0]  an;
   logic          frame_done;

   always #5 clk = ~clk;

   seven_segment_scanner #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(R),
      .DEAD_CYCLES(D),
      .ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .value     (value),
      .dp_in     (dp_in),
      .load      (load),
      .hex_mode  (hex_mode),
      .lz_en     (lz_en),
      .blank_mask(blank_mask),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .frame_done(frame_done)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected per-digit output during that digit's enabled window.
   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp_in;
      logic        hex;
      logic        lz;
      logic [3:0]  blank;
      logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
      logic [3:0]  dp_n;   // expected dp pin per digit (active-low)
      logic [3:0]  en;     // 1 = digit is enabled during its slot
   } vec_t;

   vec_t vecs[8];

   task automatic push_frame(input logic [27:0] segs, input logic [3:0] dp_n, input logic [3:0] en);
      exp_t       e;
      logic [3:0] oh;
      for (int k = 0; k < N; k++) begin
         oh    = 4'(1 << k);
         e.seg = segs[k*7 +: 7];
         e.dp  = dp_n[k];
         e.an  = en[k] ? ~oh : 4'hF;
         sb_q.push_back(e);
      end
   endtask

   // Entered at the falling edge where frame_done is high; ends at the next such edge.
   task automatic observe_frame(input string tag);
      int   j, k, c;
      exp_t e;
      for (int n = 1; n <= FRAME; n++) begin
         @(negedge clk);
         j = n - 1;
         k = j / R;
         c = j % R;
         if (c == 0) check($sformatf("%s d%0d dead_an", tag, k), 32'(an), 32'hF);
         if (c == D) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL %s d%0d scoreboard: got output, expected queue entry", tag, k);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("%s d%0d seg", tag, k), 32'(seg), 32'(e.seg));
               check($sformatf("%s d%0d dp", tag, k), 32'(dp), 32'(e.dp));
               check($sformatf("%s d%0d an", tag, k), 32'(an), 32'(e.an));
            end
         end
      end
      check($sformatf("%s frame_done", tag), 32'(frame_done), 32'h1);
   endtask

   task automatic wait_fd(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_done !== 1'b1 && n < 100);
      if (frame_done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_frame_done: got none in %0d cycles, expected pulse", n);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " an"}, 32'(an), 32'hF);
      check({tag, " seg"}, 32'(seg), 32'h7F);
      check({tag, " dp"}, 32'(dp), 32'h1);
      check({tag, " frame_done"}, 32'(frame_done), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, n;

      vecs[0] = '{16'h9876, 4'b1000, 1'b1, 1'b0, 4'b0000, {G9, G8, G7, G6}, 4'b0111, 4'b1111};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, 1'b1, 4'b0000, {OFF, OFF, G5, G0}, 4'b1111, 4'b0011};
      vecs[2] = '{16'h0050, 4'b0000, 1'b1, 1'b0, 4'b0000, {G0, G0, G5, G0}, 4'b1111, 4'b1111};
      vecs[3] = '{16'h777B, 4'b0000, 1'b1, 1'b0, 4'b0000, {G7, G7, G7, GB}, 4'b1111, 4'b1111};
      vecs[4] = '{16'h777B, 4'b0000, 1'b0, 1'b0, 4'b0000, {G7, G7, G7, DASH}, 4'b1111, 4'b1111};
      vecs[5] = '{16'h1234, 4'b0101, 1'b1, 1'b0, 4'b0100, {G1, OFF, G3, G4}, 4'b1110, 4'b1011};
      vecs[6] = '{16'h00A0, 4'b1111, 1'b1, 1'b1, 4'b0000, {OFF, OFF, GA, G0}, 4'b1100, 4'b0011};
      vecs[7] = '{16'h0000, 4'b0000, 1'b1, 1'b1, 4'b0000, {OFF, OFF, OFF, G0}, 4'b1111, 4'b0001};

      rst        = 1'b1;
      value      = '0;
      dp_in      = '0;
      load       = 1'b0;
      hex_mode   = 1'b1;
      lz_en      = 1'b0;
      blank_mask = '0;

      // Reset and scan timing after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (an !== 4'b1110 && cyc < 40);
      check("first_an_cycle", 32'(cyc), 32'd3);
      check("first_an_seg", 32'(seg), 32'(G0));
      wait_fd(n);
      check("first_frame_done_cycle", 32'(cyc + n), 32'(FRAME));
      wait_fd(n);
      check("frame_done_period", 32'(n), 32'(FRAME));

      // Tear-free load: value arrives mid-slot of digit 1 and waits for the boundary.
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge clk);
         if (i == 9) begin
            value = 16'h1234;
            load  = 1'b1;
         end
         if (i == 10) load = 1'b0;
         if (i == R + D + 1 || i == 2*R + D + 1 || i == 3*R + D + 1)
            check($sformatf("tearfree old d%0d seg", (i - 1) / R), 32'(seg), 32'(G0));
         if (i == R + D + 1) check("tearfree old d1 an", 32'(an), 32'b1101);
      end
      check("tearfree frame_done", 32'(frame_done), 32'h1);
      push_frame({G1, G2, G3, G4}, 4'hF, 4'hF);
      observe_frame("tearfree new");

      // Display vectors: each is loaded, committed at the next boundary, then observed.
      for (int v = 0; v < 8; v++) begin
         value      = vecs[v].value;
         dp_in      = vecs[v].dp_in;
         hex_mode   = vecs[v].hex;
         lz_en      = vecs[v].lz;
         blank_mask = vecs[v].blank;
         load       = 1'b1;
         @(negedge clk);
         load = 1'b0;
         wait_fd(n);
         push_frame(vecs[v].segs, vecs[v].dp_n, vecs[v].en);
         observe_frame($sformatf("vec%0d", v));
      end

      // Load on the boundary cycle: held one extra frame.
      lz_en      = 1'b0;
      hex_mode   = 1'b1;
      blank_mask = '0;
      dp_in      = '0;
      repeat (FRAME - 1) @(negedge clk);
      value = 16'h4321;
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("boundary frame_done", 32'(frame_done), 32'h1);
      push_frame({G0, G0, G0, G0}, 4'hF, 4'hF);
      observe_frame("boundary old");
      push_frame({G4, G3, G2, G1}, 4'hF, 4'hF);
      observe_frame("boundary new");

      // Reset during digit 2's slot with a load pending.
      for (int i = 1; i <= 2*R + 4; i++) begin
         @(negedge clk);
         if (i == 2*R + 1) begin
            value = 16'h9999;
            load  = 1'b1;
         end
         if (i == 2*R + 2) load = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midscan_reset");
      rst = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (an !== 4'b1110 && cyc < 40);
      check("midscan restart_cycle", 32'(cyc), 32'd3);
      check("midscan restart_seg", 32'(seg), 32'(G0));
      wait_fd(n);
      push_frame({G0, G0, G0, G0}, 4'hF, 4'hF);
      observe_frame("midscan discard");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
